// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and access-size helpers.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;
  localparam logic [2:0] SD = 3'b011;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} lsu_state_t;

  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    return 4'd1 << funct3[1:0];
  endfunction

  function automatic logic is_legal(input logic is_store, input logic [2:0] funct3,
                                    input int xlen);
    if (is_store) return !funct3[2] && ((funct3 != SD) || (xlen == 64));
    case (funct3)
      LB, LH, LW, LBU, LHU: return 1'b1;
      LD, LWU:              return xlen == 64;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction with sign/zero extension, store
// data replication and byte-strobe generation.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int  XLEN   = 32,
  localparam int LSB_W  = $clog2(XLEN / 8),
  localparam int STRB_W = XLEN / 8
) (
  input  logic [2:0]        funct3,
  input  logic [LSB_W-1:0]  offset,
  input  logic [XLEN-1:0]   rdata,
  input  logic [XLEN-1:0]   store_data,
  output logic [XLEN-1:0]   load_val,
  output logic [XLEN-1:0]   wdata,
  output logic [STRB_W-1:0] wstrb
);

  logic [XLEN-1:0] shifted;
  logic [7:0]      mask8;

  assign shifted = rdata >> {offset, 3'b000};

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statements can leave a latch behind.
  always_comb begin
    load_val = shifted;
    wdata    = store_data;
    mask8    = 8'hFF;
    case (funct3[1:0])
      2'd0: begin
        if (funct3[2]) load_val = XLEN'(shifted[7:0]);
        else           load_val = XLEN'($signed(shifted[7:0]));
        wdata = {(XLEN / 8){store_data[7:0]}};
        mask8 = 8'h01;
      end
      2'd1: begin
        if (funct3[2]) load_val = XLEN'(shifted[15:0]);
        else           load_val = XLEN'($signed(shifted[15:0]));
        wdata = {(XLEN / 16){store_data[15:0]}};
        mask8 = 8'h03;
      end
      2'd2: begin
        if (funct3[2]) load_val = XLEN'(shifted[31:0]);
        else           load_val = XLEN'($signed(shifted[31:0]));
        wdata = {(XLEN / 32){store_data[31:0]}};
        mask8 = 8'h0F;
      end
      default: ;
    endcase
  end

  assign wstrb = STRB_W'(mask8 << offset);

endmodule

// File: rtl/load_store_unit.sv
// RV32/RV64 load/store unit over a request/grant/response memory port.
// Optional build macro: LSU_MISALIGN_TRAP_EN (misaligned accesses trap instead of being rounded down).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int  XLEN   = 32,
  parameter int  ADDR_W = 32,
  localparam int LSB_W  = $clog2(XLEN / 8)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  input  logic                i_is_store,
  input  logic [2:0]          i_funct3,
  input  logic [XLEN-1:0]     i_rs1_val,
  input  logic [XLEN-1:0]     i_imm,
  input  logic [XLEN-1:0]     i_rs2_val,
  input  logic [4:0]          i_rd,
  output logic                o_stall,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [XLEN-1:0]     o_mem_wdata,
  output logic [XLEN/8-1:0]   o_mem_wstrb,
  input  logic                i_mem_gnt,
  input  logic                i_mem_rvalid,
  input  logic [XLEN-1:0]     i_mem_rdata,
  output logic                o_rd_we,
  output logic [4:0]          o_rd_addr,
  output logic [XLEN-1:0]     o_rd_wdata,
  output logic                o_misalign
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << LSB_W) - 1);

  lsu_state_t state, next_state;

  logic [XLEN-1:0]   ea;
  logic [ADDR_W-1:0] ea_addr;
  logic [LSB_W-1:0]  size_mask;
  logic              legal, trap, accept, capture, rd_we, store_active;

  logic [ADDR_W-1:0] addr_q;
  logic [LSB_W-1:0]  off_q;
  logic [2:0]        funct3_q;
  logic              store_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   sdata_q, rdata_q;

  logic [XLEN-1:0]   load_val, wdata;
  logic [XLEN/8-1:0] wstrb;

  assign ea        = i_rs1_val + i_imm;
  assign ea_addr   = ADDR_W'(ea);
  assign size_mask = LSB_W'(size_bytes(i_funct3) - 4'd1);
  assign legal     = is_legal(i_is_store, i_funct3, XLEN);

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = |(ea[LSB_W-1:0] & size_mask);
  assign trap       = misaligned;
  assign o_misalign = (state == IDLE) && i_valid && legal && misaligned;
`else
  assign trap       = 1'b0;
  assign o_misalign = 1'b0;
`endif

  assign accept  = (state == IDLE) && i_valid && legal && !trap;
  // Read data may arrive together with the grant; it must not be lost.
  assign capture = i_mem_rvalid && ((state == RESP) || ((state == REQ) && i_mem_gnt));

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      addr_q   <= '0;
      off_q    <= '0;
      funct3_q <= '0;
      store_q  <= 1'b0;
      rd_q     <= '0;
      sdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      if (accept) begin
        addr_q   <= ea_addr & ALIGN_MASK;
        // Offset bits below the access size are dropped (rounded down).
        off_q    <= ea[LSB_W-1:0] & ~size_mask;
        funct3_q <= i_funct3;
        store_q  <= i_is_store;
        rd_q     <= i_rd;
        sdata_q  <= i_rs2_val;
      end
      if (capture) rdata_q <= i_mem_rdata;
    end
  end

  always_comb begin
    next_state = state;
    o_stall    = 1'b0;
    unique case (state)
      IDLE: if (accept) begin
        next_state = REQ;
        o_stall    = 1'b1;
      end
      REQ: begin
        o_stall = 1'b1;
        if (i_mem_gnt) next_state = i_mem_rvalid ? DONE : RESP;
      end
      RESP: begin
        o_stall = 1'b1;
        if (i_mem_rvalid) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3     (funct3_q),
    .offset     (off_q),
    .rdata      (rdata_q),
    .store_data (sdata_q),
    .load_val   (load_val),
    .wdata      (wdata),
    .wstrb      (wstrb)
  );

  assign store_active = (state == REQ) && store_q;
  assign rd_we        = (state == DONE) && !store_q && (rd_q != 5'd0);

  assign o_mem_req   = (state == REQ);
  assign o_mem_we    = store_active;
  assign o_mem_addr  = o_mem_req ? addr_q : '0;
  assign o_mem_wdata = store_active ? wdata : '0;
  assign o_mem_wstrb = store_active ? wstrb : '0;
  assign o_rd_we     = rd_we;
  assign o_rd_addr   = rd_we ? rd_q : '0;
  assign o_rd_wdata  = rd_we ? load_val : '0;

endmodule
